// File: rtl/axis_pkg.sv
// Shared width-derivation helpers for the AXI-Stream width converters.
// Converters compute RATIO and counter widths from these, so all blocks agree.
package axis_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int calc_ratio(input int s_width, input int m_width);
        return s_width / m_width;
    endfunction

    // Wide enough to hold RATIO itself, not just RATIO-1.
    function automatic int calc_cntr_width(input int s_width, input int m_width);
        return clog2(calc_ratio(s_width, m_width) + 1);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: full throughput with a registered upstream ready.
// The skid entry catches the one word that arrives while the output is stalled.
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 33
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic [DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
    logic                  out_valid_reg, out_valid_next;
    logic                  skid_valid_reg, skid_valid_next;
    logic                  ready_reg, ready_next;
    logic                  in_fire;

    assign in_fire = s_valid && ready_reg;

    always_comb begin
        out_data_next   = out_data_reg;
        out_valid_next  = out_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_valid_next = skid_valid_reg;

        if (m_ready || !out_valid_reg) begin
            if (skid_valid_reg) begin
                out_data_next   = skid_data_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else begin
                out_valid_next = in_fire;
                if (in_fire) begin
                    out_data_next = s_data;
                end
            end
        end else if (in_fire) begin
            skid_data_next  = s_data;
            skid_valid_next = 1'b1;
        end

        // Ready is a flop: it only drops once the skid entry is occupied.
        ready_next = !skid_valid_next;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data_reg   <= '0;
            skid_data_reg  <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            out_data_reg   <= out_data_next;
            skid_data_reg  <= skid_data_next;
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            ready_reg      <= ready_next;
        end
    end

    assign s_ready = ready_reg;
    assign m_data  = out_data_reg;
    assign m_valid = out_valid_reg;

endmodule

// File: rtl/axis_packet_downsizer.sv
// Splits each wide input beat into N narrow output words (N from cfg_words,
// clamped to 1..RATIO), LSB- or MSB-slice first, with tlast on the final word.
module axis_packet_downsizer
    import axis_pkg::*;
#(
    parameter int S_AXIS_TDATA_WIDTH = 128,
    parameter int M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                                              aclk,
    input  logic                                                              aresetn,
    input  logic [calc_cntr_width(S_AXIS_TDATA_WIDTH, M_AXIS_TDATA_WIDTH)-1:0] cfg_words,
    input  logic                                                              cfg_order,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]                                     s_axis_tdata,
    input  logic                                                              s_axis_tvalid,
    output logic                                                              s_axis_tready,
    input  logic                                                              s_axis_tlast,
    output logic [M_AXIS_TDATA_WIDTH-1:0]                                     m_axis_tdata,
    output logic                                                              m_axis_tvalid,
    input  logic                                                              m_axis_tready,
    output logic                                                              m_axis_tlast
);

    localparam int RATIO      = calc_ratio(S_AXIS_TDATA_WIDTH, M_AXIS_TDATA_WIDTH);
    localparam int CNTR_WIDTH = calc_cntr_width(S_AXIS_TDATA_WIDTH, M_AXIS_TDATA_WIDTH);
    localparam int IDX_WIDTH  = clog2(RATIO);
    localparam int M_W        = M_AXIS_TDATA_WIDTH;

    logic [S_AXIS_TDATA_WIDTH-1:0] data_reg, data_next;
    logic                          last_reg, last_next;
    logic                          order_reg, order_next;
    logic [CNTR_WIDTH-1:0]         cnt_reg, cnt_next;
    logic [CNTR_WIDTH-1:0]         n_reg, n_next;
    logic [CNTR_WIDTH-1:0]         n_clamped;
    logic [IDX_WIDTH-1:0]          word_idx;
    logic [IDX_WIDTH-1:0]          slice_idx;
    logic [M_W-1:0]                slices [RATIO];
    logic                          buf_valid;
    logic                          buf_ready;
    logic                          push;
    logic                          accept;
    logic                          word_last;
    logic [M_W:0]                  buf_in;
    logic [M_W:0]                  buf_out;

    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
            assign slices[gi] = data_reg[gi*M_W +: M_W];
        end
    endgenerate

    always_comb begin
        n_clamped = cfg_words;
        if (cfg_words == '0) begin
            n_clamped = CNTR_WIDTH'(1);
        end else if (cfg_words > CNTR_WIDTH'(RATIO)) begin
            n_clamped = CNTR_WIDTH'(RATIO);
        end
    end

    // A non-zero counter means the latched beat still owes words downstream.
    assign buf_valid     = (cnt_reg != '0);
    assign push          = buf_valid && buf_ready;
    assign s_axis_tready = buf_ready &&
                           ((cnt_reg == '0) || ((cnt_reg == CNTR_WIDTH'(1)) && push));
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Word k of the beat is N minus the remaining count.
    assign word_idx  = IDX_WIDTH'(n_reg - cnt_reg);
    assign slice_idx = order_reg ? (IDX_WIDTH'(RATIO - 1) - word_idx) : word_idx;
    assign word_last = last_reg && (cnt_reg == CNTR_WIDTH'(1));
    assign buf_in    = {word_last, slices[slice_idx]};

    always_comb begin
        cnt_next   = cnt_reg;
        n_next     = n_reg;
        data_next  = data_reg;
        last_next  = last_reg;
        order_next = order_reg;

        if (push) begin
            cnt_next = cnt_reg - CNTR_WIDTH'(1);
        end
        // A new beat landing on the old beat's last push takes priority.
        if (accept) begin
            cnt_next   = n_clamped;
            n_next     = n_clamped;
            data_next  = s_axis_tdata;
            last_next  = s_axis_tlast;
            order_next = cfg_order;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_reg   <= '0;
            n_reg     <= '0;
            data_reg  <= '0;
            last_reg  <= 1'b0;
            order_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            n_reg     <= n_next;
            data_reg  <= data_next;
            last_reg  <= last_next;
            order_reg <= order_next;
        end
    end

    axis_skid_buffer #(
        .DATA_WIDTH(M_W + 1)
    ) u_out_buf (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_data  (buf_in),
        .s_valid (buf_valid),
        .s_ready (buf_ready),
        .m_data  (buf_out),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign m_axis_tdata = buf_out[M_W-1:0];
    assign m_axis_tlast = buf_out[M_W];

endmodule
